// File: rtl/tmp3_sampler.sv
// Autonomous TMP3 poller: issues an update every PERIOD cycles, captures the reading and keeps
// a block average, signed min/max since clear, a hysteresis alarm and a sticky timeout flag.
module tmp3_sampler #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned PERIOD   = 100_000_000,
    parameter int unsigned TIMEOUT  = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear_stats,
    input  logic [DATA_W-1:0] th_high,
    input  logic [DATA_W-1:0] th_low,
    input  logic              busy,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] temperature_i,
    output logic              update,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic [DATA_W-1:0] average,
    output logic              avg_valid,
    output logic [DATA_W-1:0] min_t,
    output logic [DATA_W-1:0] max_t,
    output logic              stats_valid,
    output logic              alarm,
    output logic              timeout_err
);

    localparam int unsigned AccW = DATA_W + AVG_LOG2;
    localparam int unsigned PerW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CntW = AVG_LOG2 + 1;

    localparam logic [PerW-1:0]   PerLast  = PerW'(PERIOD - 1);
    localparam logic [ToW-1:0]    ToLoad   = ToW'(TIMEOUT - 1);
    localparam logic [CntW-1:0]   BlockLen = CntW'(1 << AVG_LOG2);
    localparam logic [DATA_W-1:0] MostPos  = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] MostNeg  = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StRequest,
        StWaitValid,
        StAccum
    } state_e;

    state_e                   state_q;
    logic [PerW-1:0]          per_cnt_q;
    logic                     pending_q;
    logic [ToW-1:0]           to_cnt_q;
    logic                     update_q;
    logic [DATA_W-1:0]        sample_q;
    logic                     sample_valid_q;
    logic signed [AccW-1:0]   acc_q;
    logic [CntW-1:0]          cnt_q;
    logic [DATA_W-1:0]        average_q;
    logic                     avg_valid_q;
    logic [DATA_W-1:0]        min_q;
    logic [DATA_W-1:0]        max_q;
    logic                     stats_valid_q;
    logic                     alarm_q;
    logic                     timeout_err_q;

    logic                     wrap;
    logic                     tick;
    logic signed [DATA_W-1:0] sample_s;
    logic signed [AccW-1:0]   sample_ext;
    logic signed [AccW-1:0]   acc_d;
    logic signed [AccW-1:0]   acc_shift;
    logic [DATA_W-1:0]        avg_d;
    logic [CntW-1:0]          cnt_d;
    logic                     block_done;
    logic [DATA_W-1:0]        min_d;
    logic [DATA_W-1:0]        max_d;

    always_comb begin
        // The period counter free-runs outside IDLE so a slow response does not stretch the poll rate.
        wrap       = (state_q != StIdle) && (per_cnt_q == PerLast);
        tick       = wrap || pending_q;
        sample_s   = sample_q;
        sample_ext = AccW'(sample_s);
        acc_d      = acc_q + sample_ext;
        acc_shift  = acc_d >>> AVG_LOG2;
        avg_d      = acc_shift[DATA_W-1:0];
        cnt_d      = cnt_q + CntW'(1);
        block_done = (cnt_d == BlockLen);
        min_d      = ($signed(sample_q) < $signed(min_q)) ? sample_q : min_q;
        max_d      = ($signed(sample_q) > $signed(max_q)) ? sample_q : max_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            per_cnt_q      <= '0;
            pending_q      <= 1'b0;
            to_cnt_q       <= '0;
            update_q       <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            average_q      <= '0;
            avg_valid_q    <= 1'b0;
            min_q          <= MostPos;
            max_q          <= MostNeg;
            stats_valid_q  <= 1'b0;
            alarm_q        <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            update_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            avg_valid_q    <= 1'b0;

            if (state_q == StIdle || wrap) begin
                per_cnt_q <= '0;
            end else begin
                per_cnt_q <= per_cnt_q + PerW'(1);
            end

            // At most one outstanding tick: repeated wraps while blocked collapse into one request.
            if (state_q == StIdle) begin
                pending_q <= 1'b0;
            end else if (state_q == StWaitTick && enable && tick && !busy) begin
                pending_q <= 1'b0;
            end else if (wrap) begin
                pending_q <= 1'b1;
            end

            if (avg_valid_q) begin
                if ($signed(average_q) >= $signed(th_high)) begin
                    alarm_q <= 1'b1;
                end else if ($signed(average_q) <= $signed(th_low)) begin
                    alarm_q <= 1'b0;
                end
            end

            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StWaitTick;
                    end
                end
                StWaitTick: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (tick && !busy) begin
                        state_q  <= StRequest;
                        update_q <= 1'b1;
                    end
                end
                StRequest: begin
                    to_cnt_q <= ToLoad;
                    state_q  <= StWaitValid;
                end
                StWaitValid: begin
                    if (valid_i) begin
                        sample_q       <= temperature_i;
                        sample_valid_q <= 1'b1;
                        state_q        <= StAccum;
                    end else if (to_cnt_q == '0) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= enable ? StWaitTick : StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q - ToW'(1);
                    end
                end
                StAccum: begin
                    state_q <= enable ? StWaitTick : StIdle;
                    if (!clear_stats) begin
                        min_q         <= min_d;
                        max_q         <= max_d;
                        stats_valid_q <= 1'b1;
                        if (block_done) begin
                            average_q   <= avg_d;
                            avg_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (clear_stats) begin
                acc_q         <= '0;
                cnt_q         <= '0;
                min_q         <= MostPos;
                max_q         <= MostNeg;
                stats_valid_q <= 1'b0;
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign update       = update_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign average      = average_q;
    assign avg_valid    = avg_valid_q;
    assign min_t        = min_q;
    assign max_t        = max_q;
    assign stats_valid  = stats_valid_q;
    assign alarm        = alarm_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_tmp3_sampler.sv
// Bench for tmp3_sampler: scenario tasks drive a sensor stand-in and compare against a
// block-average / min / max / hysteresis model built from plain integer arithmetic.
module tb_tmp3_sampler;

    localparam int PER = 8;
    localparam int TO  = 16;
    localparam int NB  = 4;

    logic        clk = 1'b0;
    logic        rst, enable, clear_stats, busy, valid_i;
    logic [11:0] th_high, th_low, temperature_i;
    logic        update, sample_valid, avg_valid, stats_valid, alarm, timeout_err;
    logic [11:0] sample, average, min_t, max_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tmp3_sampler #(
        .DATA_W  (12),
        .AVG_LOG2(2),
        .PERIOD  (PER),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear_stats  (clear_stats),
        .th_high      (th_high),
        .th_low       (th_low),
        .busy         (busy),
        .valid_i      (valid_i),
        .temperature_i(temperature_i),
        .update       (update),
        .sample       (sample),
        .sample_valid (sample_valid),
        .average      (average),
        .avg_valid    (avg_valid),
        .min_t        (min_t),
        .max_t        (max_t),
        .stats_valid  (stats_valid),
        .alarm        (alarm),
        .timeout_err  (timeout_err)
    );

    typedef struct {
        int          ucyc;
        logic [11:0] smp, avg, mn, mx;
        logic        sv, av, stv, alm;
    } obs_t;

    // Reference model: list of samples in the current block, extremes as plain integers.
    int m_blk[$];
    int m_min, m_max, m_avg;
    bit m_stv, m_avv, m_alarm;

    function automatic int sx(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    function automatic void model_clear();
        m_blk.delete();
        m_min = 2047;
        m_max = -2048;
        m_stv = 1'b0;
    endfunction

    function automatic void model_step(input int v, input bit clr);
        int sum;
        m_avv = 1'b0;
        if (clr) begin
            model_clear();
            return;
        end
        m_blk.push_back(v);
        if (v < m_min) m_min = v;
        if (v > m_max) m_max = v;
        m_stv = 1'b1;
        if (m_blk.size() == NB) begin
            sum = 0;
            foreach (m_blk[i]) sum += m_blk[i];
            m_avg = sum / NB;
            if (sum % NB != 0 && sum < 0) m_avg = m_avg - 1;
            m_blk.delete();
            m_avv = 1'b1;
            if (m_avg >= sx(th_high)) m_alarm = 1'b1;
            else if (m_avg <= sx(th_low)) m_alarm = 1'b0;
        end
    endfunction

    // Waits for update, answers dly cycles later, observes outputs at valid+1, +2, +3.
    task automatic poll_once(input logic [11:0] val, input int dly, input bit clr, output obs_t o);
        o = '{default: '0};
        o.ucyc = -1;
        for (int i = 0; i < 4 * PER; i++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                o.ucyc = cyc;
                break;
            end
        end
        if (o.ucyc < 0) return;
        repeat (dly) @(negedge clk);
        valid_i = 1'b1;
        temperature_i = val;
        @(negedge clk);
        valid_i = 1'b0;
        clear_stats = clr;
        o.smp = sample;
        o.sv  = sample_valid;
        @(negedge clk);
        clear_stats = 1'b0;
        o.avg = average;
        o.av  = avg_valid;
        o.mn  = min_t;
        o.mx  = max_t;
        o.stv = stats_valid;
        @(negedge clk);
        o.alm = alarm;
    endtask

    task automatic test_reset();
        int n = 0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({update, sample_valid, avg_valid, stats_valid, alarm, timeout_err} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000",
                {update, sample_valid, avg_valid, stats_valid, alarm, timeout_err});
        end
        checks++; if (sample !== 12'h000 || average !== 12'h000) begin
            errors++; $display("FAIL reset_data: got sample=%h average=%h want 000/000", sample, average);
        end
        checks++; if (min_t !== 12'h7FF || max_t !== 12'h800) begin
            errors++; $display("FAIL reset_minmax: got min=%h max=%h want 7ff/800", min_t, max_t);
        end
        rst = 1'b1;
        repeat (2 * PER + 2) begin
            @(negedge clk);
            if (update === 1'b1) n++;
        end
        checks++; if (n != 0) begin
            errors++; $display("FAIL idle_no_poll: got %0d updates want 0", n);
        end
    endtask

    task automatic test_average();
        obs_t o;
        logic [11:0] v;
        int prev = -1;
        enable = 1'b1;
        for (int i = 0; i < NB; i++) begin
            v = 12'h190 + 12'(i);
            poll_once(v, 3, 1'b0, o);
            model_step(sx(v), 1'b0);
            checks++; if (o.ucyc < 0) begin
                errors++; $display("FAIL avg_update: got none want update within %0d cycles", 4 * PER);
            end
            checks++; if (o.sv !== 1'b1 || o.smp !== v) begin
                errors++; $display("FAIL avg_sample: got sv=%b smp=%h want 1/%h", o.sv, o.smp, v);
            end
            checks++; if (o.av !== m_avv) begin
                errors++; $display("FAIL avg_valid: got %b want %b (sample %0d)", o.av, m_avv, i);
            end
            if (prev >= 0) begin
                checks++; if (o.ucyc - prev != PER) begin
                    errors++; $display("FAIL poll_period: got %0d want %0d", o.ucyc - prev, PER);
                end
            end
            prev = o.ucyc;
        end
        checks++; if (o.avg !== 12'(m_avg)) begin
            errors++; $display("FAIL avg_value: got %h want %h", o.avg, 12'(m_avg));
        end
        checks++; if (sx(o.mn) != m_min || sx(o.mx) != m_max || o.stv !== 1'b1) begin
            errors++; $display("FAIL avg_minmax: got min=%h max=%h stv=%b want %h/%h/1",
                o.mn, o.mx, o.stv, 12'(m_min), 12'(m_max));
        end
    endtask

    task automatic test_negative_floor();
        obs_t o;
        logic [11:0] vals[4];
        vals = '{12'hFFF, 12'hFFE, 12'hFFF, 12'hFFE};
        clear_stats = 1'b1;
        model_clear();
        @(negedge clk);
        clear_stats = 1'b0;
        for (int i = 0; i < NB; i++) begin
            poll_once(vals[i], 3, 1'b0, o);
            model_step(sx(vals[i]), 1'b0);
            checks++; if (o.smp !== vals[i]) begin
                errors++; $display("FAIL neg_sample: got %h want %h", o.smp, vals[i]);
            end
        end
        checks++; if (o.av !== 1'b1 || o.avg !== 12'(m_avg)) begin
            errors++; $display("FAIL neg_floor: got av=%b avg=%h want 1/%h", o.av, o.avg, 12'(m_avg));
        end
        checks++; if (sx(o.mn) != m_min || sx(o.mx) != m_max) begin
            errors++; $display("FAIL neg_minmax: got min=%h max=%h want %h/%h",
                o.mn, o.mx, 12'(m_min), 12'(m_max));
        end
    endtask

    task automatic test_hysteresis();
        obs_t o;
        logic [11:0] hv[4];
        bit exp_alm[4];
        hv = '{12'h1F0, 12'h200, 12'h190, 12'h180};
        exp_alm = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < NB; s++) begin
                poll_once(hv[b], 3, 1'b0, o);
                model_step(sx(hv[b]), 1'b0);
            end
            checks++; if (o.av !== 1'b1 || o.avg !== hv[b]) begin
                errors++; $display("FAIL hyst_avg: got av=%b avg=%h want 1/%h", o.av, o.avg, hv[b]);
            end
            checks++; if (o.alm !== exp_alm[b]) begin
                errors++; $display("FAIL hyst_alarm: got %b want %b (block %0d)", o.alm, exp_alm[b], b);
            end
        end
    endtask

    task automatic test_clear_coincident();
        obs_t o;
        poll_once(12'h050, 3, 1'b1, o);
        model_step(sx(12'h050), 1'b1);
        checks++; if (o.sv !== 1'b1 || o.smp !== 12'h050) begin
            errors++; $display("FAIL clr_sample: got sv=%b smp=%h want 1/050", o.sv, o.smp);
        end
        checks++; if (o.stv !== 1'b0 || o.mn !== 12'h7FF || o.mx !== 12'h800) begin
            errors++; $display("FAIL clr_stats: got stv=%b min=%h max=%h want 0/7ff/800",
                o.stv, o.mn, o.mx);
        end
        checks++; if (o.av !== 1'b0 || o.avg !== 12'(m_avg) || o.alm !== m_alarm) begin
            errors++; $display("FAIL clr_kept: got av=%b avg=%h alarm=%b want 0/%h/%b",
                o.av, o.avg, o.alm, 12'(m_avg), m_alarm);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [11:0] v;
        int a, b, t, d;
        bit clr;
        a = int'($urandom_range(1023)) - 512;
        b = int'($urandom_range(1023)) - 512;
        if (a > b) begin t = a; a = b; b = t; end
        th_low  = 12'(a);
        th_high = 12'(b);
        for (int i = 0; i < 16; i++) begin
            v   = 12'($urandom_range(4095));
            d   = int'($urandom_range(4, 1));
            clr = ($urandom_range(7) == 0);
            poll_once(v, d, clr, o);
            model_step(sx(v), clr);
            checks++; if (o.sv !== 1'b1 || o.smp !== v) begin
                errors++; $display("FAIL rnd_sample: got sv=%b smp=%h want 1/%h", o.sv, o.smp, v);
            end
            checks++; if (o.stv !== m_stv || sx(o.mn) != m_min || sx(o.mx) != m_max) begin
                errors++; $display("FAIL rnd_stats: got stv=%b min=%h max=%h want %b/%h/%h",
                    o.stv, o.mn, o.mx, m_stv, 12'(m_min), 12'(m_max));
            end
            checks++; if (o.av !== m_avv || (m_avv && o.avg !== 12'(m_avg))) begin
                errors++; $display("FAIL rnd_avg: got av=%b avg=%h want %b/%h",
                    o.av, o.avg, m_avv, 12'(m_avg));
            end
            checks++; if (o.alm !== m_alarm) begin
                errors++; $display("FAIL rnd_alarm: got %b want %b", o.alm, m_alarm);
            end
        end
    endtask

    task automatic test_busy();
        obs_t o;
        int n = 0, c;
        logic sv6;
        logic [11:0] s6;
        sv6 = 1'b0;
        s6 = '0;
        poll_once(12'h0A5, 3, 1'b0, o);
        model_step(sx(12'h0A5), 1'b0);
        checks++; if (o.smp !== 12'h0A5) begin
            errors++; $display("FAIL busy_pre: got %h want 0a5", o.smp);
        end
        busy = 1'b1;
        c = cyc;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (update === 1'b1) n++;
            if (i == 6) begin
                sv6 = sample_valid;
                s6  = sample;
            end
            valid_i = (i == 5);
            temperature_i = 12'h7AB;
        end
        busy = 1'b0;
        valid_i = 1'b0;
        checks++; if (n != 0) begin
            errors++; $display("FAIL busy_block: got %0d updates want 0", n);
        end
        checks++; if (sv6 !== 1'b0 || s6 !== 12'h0A5) begin
            errors++; $display("FAIL stray_valid: got sv=%b smp=%h want 0/0a5", sv6, s6);
        end
        poll_once(12'h0B6, 1, 1'b0, o);
        model_step(sx(12'h0B6), 1'b0);
        checks++; if (o.ucyc != c + 21) begin
            errors++; $display("FAIL busy_release: got update cycle %0d want %0d", o.ucyc, c + 21);
        end
        checks++; if (o.smp !== 12'h0B6 || o.stv !== m_stv) begin
            errors++; $display("FAIL busy_sample: got smp=%h stv=%b want 0b6/%b", o.smp, o.stv, m_stv);
        end
    endtask

    task automatic test_timeout();
        int u = -1, nu = -1, n = 0;
        enable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (update === 1'b1) n++;
        end
        checks++; if (n != 0) begin
            errors++; $display("FAIL disable_idle: got %0d updates want 0", n);
        end
        enable = 1'b1;
        for (int i = 0; i < 3 * PER; i++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                u = cyc;
                break;
            end
        end
        checks++; if (u < 0) begin
            errors++; $display("FAIL to_update: got none want update within %0d cycles", 3 * PER);
        end
        n = 0;
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) n++;
            if (k == TO) begin
                checks++; if (timeout_err !== 1'b0) begin
                    errors++; $display("FAIL to_early: got %b want 0 at u+%0d", timeout_err, k);
                end
            end
        end
        checks++; if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_set: got %b want 1 at u+%0d", timeout_err, TO + 1);
        end
        checks++; if (n != 0 || sx(min_t) != m_min || sx(max_t) != m_max) begin
            errors++; $display("FAIL to_nosample: got sv_count=%0d min=%h max=%h want 0/%h/%h",
                n, min_t, max_t, 12'(m_min), 12'(m_max));
        end
        for (int i = 0; i < 2 * PER + 2; i++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                nu = cyc;
                break;
            end
        end
        checks++; if (nu < 0) begin
            errors++; $display("FAIL to_repoll: got none want update within %0d cycles", 2 * PER + 2);
        end
        clear_stats = 1'b1;
        model_clear();
        @(negedge clk);
        clear_stats = 1'b0;
        checks++; if (timeout_err !== 1'b0 || stats_valid !== 1'b0) begin
            errors++; $display("FAIL to_clear: got err=%b stv=%b want 0/0", timeout_err, stats_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        clear_stats = 1'b0;
        busy = 1'b0;
        valid_i = 1'b0;
        temperature_i = '0;
        th_high = 12'h200;
        th_low = 12'h180;
        m_alarm = 1'b0;
        m_avg = 0;
        m_avv = 1'b0;
        model_clear();
        test_reset();
        test_average();
        test_negative_floor();
        test_hysteresis();
        test_clear_coincident();
        test_random();
        test_busy();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmp3_sampler.md
# tmp3_sampler

Autonomous polling and statistics engine for the Pmod TMP3 interface: it issues periodic `update` requests, captures each returned temperature, and maintains a block average, running min/max and a hysteresis alarm. It replaces the button-driven single-shot capture used on the board test path. It also lets display and alert logic work on filtered, signed temperature data. Parametrised in sample width, averaging depth, poll period and response timeout.

## Interface
- `DATA_W`, 12, temperature width, two's complement, LSB = 1/16 °C
- `AVG_LOG2`, 2, averaging window of 2^AVG_LOG2 samples (0 = no averaging)
- `PERIOD`, 100_000_000, clock cycles between poll requests (≥ 4)
- `TIMEOUT`, 1_000_000, cycles allowed from `update` to `valid_i`
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  level; polling runs while high
- `clear_stats`  in  1  one-cycle pulse; clears accumulator, min/max, `timeout_err`
- `th_high`, `th_low`  in  DATA_W  signed alarm set/clear thresholds (`th_low` ≤ `th_high`)
- `busy`  in  1  TMP3 interface busy
- `valid_i`  in  1  one-cycle strobe, `temperature_i` valid
- `temperature_i`  in  DATA_W  measured temperature
- `update`  out  1  one-cycle read request to TMP3 interface
- `sample`  out  DATA_W  last captured temperature
- `sample_valid`  out  1  one-cycle strobe, new `sample`
- `average`  out  DATA_W  last block average
- `avg_valid`  out  1  one-cycle strobe, new `average`
- `min_t`, `max_t`  out  DATA_W  signed extremes since last clear
- `stats_valid`  out  1  high once ≥ 1 sample accumulated since clear
- `alarm`  out  1  hysteresis alarm on `average`
- `timeout_err`  out  1  sticky, set on missing response

## Operation
- Reset values: `update`, `sample_valid`, `avg_valid`, `stats_valid`, `alarm`, `timeout_err` = 0; `sample`, `average` = 0; `min_t` = most positive (0x7FF at 12 b), `max_t` = most negative (0x800); accumulator, counters = 0; state IDLE.
- FSM states:
  - IDLE: period counter held at 0. `enable` high → WAIT_TICK.
  - WAIT_TICK: counter counts 0..PERIOD-1 and wraps; wrap sets `pending`. `pending` & !`busy` → REQUEST, clearing `pending`. A wrap while `busy` keeps `pending` set; it does not queue a second request. `enable` low → IDLE.
  - REQUEST: `update`=1 for exactly one cycle; timeout counter loaded → WAIT_VALID.
  - WAIT_VALID: on `valid_i`, `temperature_i` is latched into `sample` → ACCUM. If the counter expires first, `timeout_err` is set and no sample is taken → WAIT_TICK, or IDLE if `enable` is low. `enable` low does not abort this state.
  - ACCUM: `sample_valid`=1. Sign-extended sample is added into a DATA_W+AVG_LOG2 accumulator. Signed min/max are updated. `stats_valid` is set and the sample count increments. When the count reaches 2^AVG_LOG2: `average` = accumulator arithmetically shifted right by AVG_LOG2 (floor toward −∞), then accumulator and count clear. → WAIT_TICK, or IDLE if `enable` is low.
- Alarm, evaluated only on each new `average`: set if `average` ≥ `th_high`; cleared if `average` ≤ `th_low`; otherwise held.
- `clear_stats` has priority over ACCUM updates in the same cycle. It clears accumulator, count, min/max (to reset sentinels), `stats_valid` and `timeout_err`. That sample still appears on `sample`/`sample_valid` but is excluded from stats. `alarm` and `average` are kept.
- Period counter keeps running during a transaction, so the poll rate is exactly PERIOD when the sensor responds in time.

## Timing
- `update` is asserted the cycle after the tick is accepted (REQUEST state), never while `busy`=1 is sampled.
- `valid_i` high in cycle t → `sample`/`sample_valid` in t+1 → `average`/`avg_valid`, `min_t`/`max_t` in t+2; `alarm` in t+3.
- `valid_i` outside WAIT_VALID is ignored.
- Timeout: `update` in cycle u with no `valid_i` → `timeout_err` high from cycle u+TIMEOUT+1.
- Reset deassertion mid-transaction returns to IDLE; the first `update` follows PERIOD cycles after `enable` is seen high.

## Test plan
- PERIOD=8, AVG_LOG2=2, sensor model answers 3 cycles after `update` with 0x190, 0x191, 0x192, 0x193 → four `sample_valid`, one `avg_valid` with `average`=0x191, `min_t`=0x190, `max_t`=0x193, `update` every 8 cycles.
- Negative floor: samples 0xFFF, 0xFFE, 0xFFF, 0xFFE (−1, −2, −1, −2) → `average`=0xFFE (−2), `min_t`=0xFFE, `max_t`=0xFFF.
- Hysteresis: `th_high`=0x200, `th_low`=0x180; averages 0x1F0, 0x200, 0x190, 0x180 → `alarm` 0,1,1,0.
- Timeout: TIMEOUT=16, sensor never responds → `timeout_err`=1 at u+17, FSM re-polls next tick; `clear_stats` → `timeout_err`=0.
- `busy` held high across a tick for 20 cycles → exactly one `update`, issued the cycle after `busy` falls.
- `clear_stats` coincident with ACCUM of sample 0x050 → `sample`=0x050 with `sample_valid`, `stats_valid`=0, `min_t`=0x7FF, `max_t`=0x800.
